guess_ctrl: RTL and testbench
=============================

# guess_ctrl

Game controller for the guess-the-number datapath. Samples the free-running 4-bit pseudo-random generator to pick a secret, takes player guesses from a button, and reports higher/lower per guess. Counts remaining attempts and ends the round in WIN or LOSE. Sits between the random generator and the button/LED/seven-segment front end.

## Interface
- WIDTH, 4, bit width of the random value, guess and secret
- MAX_TRIES, 4, guesses allowed per round (1..15)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising clk)
- rnd  input  WIDTH  current output of the pseudo-random generator, free-running
- start_btn  input  1  level from debounced start button; rising edge is the event
- guess_btn  input  1  level from debounced guess button; rising edge is the event
- guess  input  WIDTH  player guess from switches, sampled on a guess event
- state  output  2  0=IDLE, 1=PLAY, 2=WIN, 3=LOSE
- too_high  output  1  last evaluated guess > secret
- too_low  output  1  last evaluated guess < secret
- win  output  1  high in WIN
- lose  output  1  high in LOSE
- tries_left  output  4  remaining guesses
- secret_out  output  WIDTH  secret in WIN/LOSE, else 0

## Operation
- Edge detect: registers start_q and guess_q hold the previous samples.
  - start_ev = start_btn & ~start_q.
  - guess_ev = guess_btn & ~guess_q.
  - On reset, both previous-sample registers load 1, so a button held through reset release does not fire.
- IDLE:
  - On start_ev: secret <= rnd, tries_left <= MAX_TRIES, too_high/too_low <= 0, go to PLAY.
  - guess_ev is ignored.
- PLAY, on guess_ev (no start_ev): compare guess with secret (unsigned).
  - guess == secret: too_high = too_low = 0, tries_left decrements, go to WIN.
  - guess != secret: set too_high or too_low, tries_left decrements. If tries_left was 1, go to LOSE, else stay in PLAY.
- PLAY, on start_ev (with or without guess_ev): restart the round exactly as the IDLE start. A coincident guess is discarded.
- WIN / LOSE:
  - guess_ev is ignored and flags hold their last values.
  - start_ev starts a new round directly (same actions as the IDLE start).
- A correct guess on the final try is a WIN, not a LOSE.
- Any rnd value is a legal secret, including 0 and all-ones. No re-draw.
- secret_out = secret when state is WIN or LOSE, else 0. win/lose are decoded from state.
- tries_left never underflows: it decrements only on an evaluated guess in PLAY.

## Timing
- All outputs are registered. A button level first sampled high at rising edge N (previous sample 0) produces the updated outputs after edge N: 1-cycle latency from input to output.
- Minimum event spacing is 2 cycles: the button must be sampled low at least once between events.
- rnd and guess are sampled at the same edge that detects the event.
- Reset (reset=0 at a rising edge), from any state including mid-round:
  - state=IDLE, too_high=0, too_low=0, win=0, lose=0, tries_left=0, secret_out=0, secret=0.
  - start_q=1, guess_q=1.
- A reset asserted in the same cycle as any event dominates: the event is lost.

## Test plan
- Reset with both buttons held high, release reset, keep buttons high for 5 cycles -> state stays 0 and no event fires. Drop and re-raise start_btn -> state=1.
- rnd=4'h9 at start edge; guesses 4'h3, 4'hC, 4'h9 -> after each: too_low=1 with tries_left=3; too_high=1 with tries_left=2; win=1, state=2, secret_out=9, tries_left=1.
- secret=4'h5, MAX_TRIES=4, guesses 0,1,2,3 -> after the 4th: lose=1, state=3, tries_left=0, secret_out=5. A further guess_ev -> no change.
- secret=4'hF, three wrong guesses, then guess 4'hF on the last try -> WIN, tries_left=0, lose=0.
- In PLAY, start and guess edges in the same cycle with rnd=4'h2 -> secret=2, tries_left=MAX_TRIES, flags 0, guess discarded.
- Mid-round (tries_left=2) assert reset for 1 cycle -> all outputs at reset values, state=0. Next start_ev begins a fresh round with tries_left=4.

Source files
------------

// File: rtl/guess_ctrl.sv
// guess_ctrl: round controller for the guess-the-number game.
// Picks a secret from the free-running random source on a start press,
// grades each guess press as higher/lower/equal, counts down the remaining
// attempts and ends the round in WIN or LOSE. All outputs come from registers.
//
// Button handshake: start_btn and guess_btn are debounced levels; an event is
// a 0->1 transition between two consecutive rising-edge samples. There is no
// ready/back-pressure: an event is consumed in the cycle it is detected, or
// dropped if the current state does not accept it.
module guess_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rnd,
  input  logic             start_btn,
  input  logic             guess_btn,
  input  logic [WIDTH-1:0] guess,
  output logic [1:0]       state,
  output logic             too_high,
  output logic             too_low,
  output logic             win,
  output logic             lose,
  output logic [3:0]       tries_left,
  output logic [WIDTH-1:0] secret_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] secret_q, secret_d;
  logic [3:0]       tries_q, tries_d;
  logic             too_high_q, too_high_d;
  logic             too_low_q, too_low_d;
  logic             start_q, guess_q;

  logic start_ev;
  logic guess_ev;

  // Rising-edge detection against the previous sample.
  assign start_ev = start_btn & ~start_q;
  assign guess_ev = guess_btn & ~guess_q;

  // State and datapath registers; previous-sample registers reset high so a
  // button already held through reset release does not fire an event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      secret_q   <= '0;
      tries_q    <= 4'd0;
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
      start_q    <= 1'b1;
      guess_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      secret_q   <= secret_d;
      tries_q    <= tries_d;
      too_high_q <= too_high_d;
      too_low_q  <= too_low_d;
      start_q    <= start_btn;
      guess_q    <= guess_btn;
    end
  end

  // Next-state logic: start restarts the round from any state and wins over a
  // coincident guess; guesses are graded only while playing.
  always_comb begin
    state_d    = state_q;
    secret_d   = secret_q;
    tries_d    = tries_q;
    too_high_d = too_high_q;
    too_low_d  = too_low_q;
    if (start_ev) begin
      state_d    = S_PLAY;
      secret_d   = rnd;
      tries_d    = 4'(MAX_TRIES);
      too_high_d = 1'b0;
      too_low_d  = 1'b0;
    end else if (guess_ev && state_q == S_PLAY) begin
      tries_d = tries_q - 4'd1;
      if (guess == secret_q) begin
        too_high_d = 1'b0;
        too_low_d  = 1'b0;
        state_d    = S_WIN;
      end else begin
        too_high_d = (guess > secret_q);
        too_low_d  = (guess < secret_q);
        state_d    = (tries_q == 4'd1) ? S_LOSE : S_PLAY;
      end
    end
  end

  // Outputs are decoded directly from registered state.
  assign state      = state_q;
  assign too_high   = too_high_q;
  assign too_low    = too_low_q;
  assign win        = (state_q == S_WIN);
  assign lose       = (state_q == S_LOSE);
  assign tries_left = tries_q;
  assign secret_out = (state_q == S_WIN || state_q == S_LOSE) ? secret_q : '0;

endmodule

// File: tb/tb_guess_ctrl.sv
// Testbench for guess_ctrl: directed scenarios plus randomized traffic, all
// checked against a rule-level model of the game kept in this file.
module tb_guess_ctrl;

  localparam int WIDTH     = 4;
  localparam int MAX_TRIES = 4;

  // Clock / reset block
  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rnd;
  logic             start_btn;
  logic             guess_btn;
  logic [WIDTH-1:0] guess;
  logic [1:0]       state;
  logic             too_high, too_low, win, lose;
  logic [3:0]       tries_left;
  logic [WIDTH-1:0] secret_out;

  always #5 clk = ~clk;

  guess_ctrl #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (
    .clk        (clk),
    .reset      (reset),
    .rnd        (rnd),
    .start_btn  (start_btn),
    .guess_btn  (guess_btn),
    .guess      (guess),
    .state      (state),
    .too_high   (too_high),
    .too_low    (too_low),
    .win        (win),
    .lose       (lose),
    .tries_left (tries_left),
    .secret_out (secret_out)
  );

  int checks   = 0;
  int failures = 0;

  // Game model: what the player should see, described by the game rules.
  int   m_state;   // 0 idle, 1 play, 2 win, 3 lose
  int   m_secret;
  int   m_tries;
  bit   m_hi, m_lo;
  bit   m_start_prev, m_guess_prev;

  logic [13:0] act_vec;
  assign act_vec = {state, too_high, too_low, win, lose, tries_left, secret_out};

  function automatic logic [13:0] exp_vec();
    logic [3:0] so;
    so = (m_state >= 2) ? 4'(m_secret) : 4'd0;
    return {2'(m_state), m_hi, m_lo, (m_state == 2), (m_state == 3), 4'(m_tries), so};
  endfunction

  task automatic model_clock(input bit rst_n, input bit sb, input bit gb,
                             input int g, input int r);
    bit sev, gev;
    if (!rst_n) begin
      m_state = 0; m_secret = 0; m_tries = 0; m_hi = 0; m_lo = 0;
      m_start_prev = 1; m_guess_prev = 1;
      return;
    end
    sev = sb && !m_start_prev;
    gev = gb && !m_guess_prev;
    m_start_prev = sb;
    m_guess_prev = gb;
    if (sev) begin
      m_state = 1; m_secret = r; m_tries = MAX_TRIES; m_hi = 0; m_lo = 0;
    end else if (gev && m_state == 1) begin
      m_tries = m_tries - 1;
      if (g == m_secret) begin
        m_state = 2; m_hi = 0; m_lo = 0;
      end else begin
        m_hi = (g > m_secret);
        m_lo = (g < m_secret);
        m_state = (m_tries == 0) ? 3 : 1;
      end
    end
  endtask

  // Driver: apply inputs at the falling edge, advance the model at the rising
  // edge, and leave the caller 1 time unit after that edge to sample outputs.
  task automatic tick(input bit rst_n, input bit sb, input bit gb,
                      input int g, input int r);
    @(negedge clk);
    reset     = rst_n;
    start_btn = sb;
    guess_btn = gb;
    guess     = 4'(g);
    rnd       = 4'(r);
    @(posedge clk);
    model_clock(rst_n, sb, gb, g, r);
    #1;
  endtask

  // Start a new round with the given random value (start button pressed then released).
  task automatic start_round(input int r);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, r);
    tick(1, 0, 0, 0, 0);
  endtask

  // One guess press; leaves the button high (release comes with the next tick).
  task automatic press_guess(input int g);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, g, $urandom_range(0, 15));
  endtask

  task automatic test_reset();
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    checks++;
    if (act_vec !== 14'd0) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", act_vec, 14'd0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 3, 7);
      checks++;
      if (state !== 2'd0 || act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL held_buttons_no_event[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 1, 0, 6);
    checks++;
    if (state !== 2'd1 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL start_after_release: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_win_sequence();
    start_round(9);
    press_guess(3);
    checks++;
    if (too_low !== 1'b1 || too_high !== 1'b0 || tries_left !== 4'd3 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL win_seq_low: got %h expected %h", act_vec, exp_vec());
    end
    press_guess(12);
    checks++;
    if (too_high !== 1'b1 || too_low !== 1'b0 || tries_left !== 4'd2 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL win_seq_high: got %h expected %h", act_vec, exp_vec());
    end
    press_guess(9);
    checks++;
    if (win !== 1'b1 || state !== 2'd2 || secret_out !== 4'd9 || tries_left !== 4'd1 ||
        act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL win_seq_hit: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_lose();
    logic [13:0] snap;
    start_round(5);
    for (int i = 0; i < 4; i++) press_guess(i);
    checks++;
    if (lose !== 1'b1 || state !== 2'd3 || tries_left !== 4'd0 || secret_out !== 4'd5 ||
        act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL lose_after_max: got %h expected %h", act_vec, exp_vec());
    end
    snap = exp_vec();
    press_guess(5);
    checks++;
    if (act_vec !== snap) begin
      failures++;
      $display("FAIL guess_in_lose_ignored: got %h expected %h", act_vec, snap);
    end
  endtask

  task automatic test_last_try_win();
    start_round(15);
    press_guess(1);
    press_guess(2);
    press_guess(3);
    press_guess(15);
    checks++;
    if (state !== 2'd2 || tries_left !== 4'd0 || lose !== 1'b0 || win !== 1'b1 ||
        secret_out !== 4'hF || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL last_try_win: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_coincident_start_guess();
    start_round(7);
    press_guess(1);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 2, 2);
    checks++;
    if (state !== 2'd1 || tries_left !== 4'(MAX_TRIES) || too_high !== 1'b0 ||
        too_low !== 1'b0 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL start_beats_guess: got %h expected %h", act_vec, exp_vec());
    end
    tick(1, 0, 0, 0, 0);
    press_guess(2);
    checks++;
    if (state !== 2'd2 || secret_out !== 4'd2 || tries_left !== 4'(MAX_TRIES - 1)) begin
      failures++;
      $display("FAIL restart_secret: got %h expected state=2 secret=2 tries=%0d",
               act_vec, MAX_TRIES - 1);
    end
  endtask

  task automatic test_reset_midround();
    start_round(11);
    press_guess(0);
    press_guess(1);
    checks++;
    if (tries_left !== 4'd2 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL midround_setup: got %h expected %h", act_vec, exp_vec());
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (act_vec !== 14'd0) begin
      failures++;
      $display("FAIL midround_reset: got %h expected %h", act_vec, 14'd0);
    end
    start_round(4);
    checks++;
    if (state !== 2'd1 || tries_left !== 4'd4 || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL fresh_round: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit rst_n;
      rst_n = ($urandom_range(0, 63) != 0);
      tick(rst_n, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15), $urandom_range(0, 15));
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; start_btn = 1'b1; guess_btn = 1'b1; guess = '0; rnd = '0;
    model_clock(0, 1, 1, 0, 0);
    test_reset();
    test_win_sequence();
    test_lose();
    test_last_try_win();
    test_coincident_start_guess();
    test_reset_midround();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
